// File: rtl/aer_in_sender_pkg.sv
// Shared definitions for the host-side AER input transmitter: address layout
// and the handshake FSM state type.
package aer_in_sender_pkg;

  localparam int AER_AW = 12;

  // Event-type field sits in the top two address bits, the address below it.
  localparam int AER_TYPE_MSB = AER_AW - 1;
  localparam int AER_TYPE_LSB = AER_AW - 2;
  localparam int AER_ADDR_MSB = AER_AW - 3;

  typedef enum logic [1:0] {
    AER_EV_NEURON  = 2'b00,
    AER_EV_SYNAPSE = 2'b01,
    AER_EV_VIRTUAL = 2'b10,
    AER_EV_CONFIG  = 2'b11
  } aer_ev_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_REQ_HI = 2'b10,
    ST_ACK_LO = 2'b11
  } aer_state_e;

  function automatic aer_ev_type_e aer_ev_type(input logic [AER_AW-1:0] ev);
    return aer_ev_type_e'(ev[AER_TYPE_MSB:AER_TYPE_LSB]);
  endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Synchronous event FIFO: DEPTH x AW storage, head word always presented,
// full/empty flags and an occupancy count that tracks the current edge.
module aer_sync_fifo
  import aer_in_sender_pkg::*;
#(
  parameter  int AW    = AER_AW,
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] push_data,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged before this edge's pop, so a pop never frees a slot
  // for a push landing on the same edge.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; pointers and level define which words are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/aer_in_sender.sv
// Host-side AER transmitter: queues events and drives the core's 4-phase
// ADDR/REQ/ACK input port with ADDR held stable across each handshake.
module aer_in_sender
  import aer_in_sender_pkg::*;
#(
  parameter  int AW    = AER_AW,
  parameter  int DEPTH = 16,
  parameter  int SYNC  = 2,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] EV_DATA,
  input  logic          EV_VALID,
  output logic          EV_READY,
  output logic [AW-1:0] AERIN_ADDR,
  output logic          AERIN_REQ,
  input  logic          AERIN_ACK,
  output logic          BUSY,
  output logic [LW-1:0] FIFO_LEVEL,
  output logic [15:0]   EV_SENT_CNT
);

  aer_state_e    state;
  aer_state_e    state_n;
  logic [SYNC-1:0] ack_sync;
  logic          ack_s;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW-1:0] head;
  logic [15:0]   sent_cnt;

  aer_sync_fifo #(.AW(AW), .DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push_data (EV_DATA),
    .push      (EV_VALID),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (FIFO_LEVEL)
  );

  // ACK arrives from another timing domain; only the synchronised copy is used.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC-2:0], AERIN_ACK};
  end
  assign ack_s = ack_sync[SYNC-1];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        // A stale ACK from the core blocks the next request until it clears.
        if (!empty && !ack_s) begin
          pop     = 1'b1;
          state_n = ST_SETUP;
        end
      end
      ST_SETUP:  state_n = ST_REQ_HI;
      ST_REQ_HI: if (ack_s)  state_n = ST_ACK_LO;
      ST_ACK_LO: if (!ack_s) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      AERIN_ADDR <= '0;
      AERIN_REQ  <= 1'b0;
      sent_cnt   <= '0;
    end else begin
      state <= state_n;
      if (pop)                          AERIN_ADDR <= head;
      if (state == ST_SETUP)            AERIN_REQ  <= 1'b1;
      if (state == ST_REQ_HI && ack_s)  AERIN_REQ  <= 1'b0;
      if (state == ST_ACK_LO && !ack_s) sent_cnt   <= sent_cnt + 16'd1;
    end
  end

  assign EV_READY    = !full;
  assign BUSY        = !empty || (state != ST_IDLE);
  assign EV_SENT_CNT = sent_cnt;

endmodule

// File: tb/tb_aer_in_sender.sv
// Directed bench for aer_in_sender: one task per scenario, inline comparisons
// against hand-computed values, single summary line at the end.
module tb_aer_in_sender;

  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] EV_DATA;
  logic          EV_VALID;
  logic          EV_READY;
  logic [AW-1:0] AERIN_ADDR;
  logic          AERIN_REQ;
  logic          AERIN_ACK;
  logic          BUSY;
  logic [LW-1:0] FIFO_LEVEL;
  logic [15:0]   EV_SENT_CNT;

  int checks = 0;
  int errors = 0;

  aer_in_sender #(.AW(AW), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EV_DATA     (EV_DATA),
    .EV_VALID    (EV_VALID),
    .EV_READY    (EV_READY),
    .AERIN_ADDR  (AERIN_ADDR),
    .AERIN_REQ   (AERIN_REQ),
    .AERIN_ACK   (AERIN_ACK),
    .BUSY        (BUSY),
    .FIFO_LEVEL  (FIFO_LEVEL),
    .EV_SENT_CNT (EV_SENT_CNT)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST       = 1'b1;
    EV_VALID  = 1'b0;
    EV_DATA   = '0;
    AERIN_ACK = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic push_ev(input logic [AW-1:0] d);
    EV_DATA  = d;
    EV_VALID = 1'b1;
    tick();
    EV_VALID = 1'b0;
  endtask

  // One full 4-phase handshake as the core would answer it, dly cycles each way.
  task automatic respond(input int dly, output logic [AW-1:0] addr_seen);
    int n;
    n = 0;
    while (AERIN_REQ !== 1'b1 && n < 300) begin tick(); n++; end
    addr_seen = AERIN_ADDR;
    checks++;
    if (AERIN_REQ !== 1'b1) begin
      errors++;
      $display("FAIL resp_req_rise: REQ=%b after %0d cycles, required 1", AERIN_REQ, n);
    end
    repeat (dly) tick();
    AERIN_ACK = 1'b1;
    n = 0;
    while (AERIN_REQ !== 1'b0 && n < 300) begin tick(); n++; end
    checks++;
    if (AERIN_REQ !== 1'b0) begin
      errors++;
      $display("FAIL resp_req_fall: REQ=%b after %0d cycles, required 0", AERIN_REQ, n);
    end
    repeat (dly) tick();
    AERIN_ACK = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < 500) begin tick(); n++; end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: BUSY=%b after %0d cycles, required 0", tag, BUSY, n);
    end
  endtask

  task automatic test_reset();
    RST       = 1'b1;
    EV_VALID  = 1'b0;
    EV_DATA   = '0;
    AERIN_ACK = 1'b0;
    repeat (2) tick();
    checks++;
    if ({AERIN_REQ, AERIN_ADDR} !== 13'h0) begin
      errors++;
      $display("FAIL reset_req_addr: REQ=%b ADDR=%h, required 0/000", AERIN_REQ, AERIN_ADDR);
    end
    checks++;
    if ({EV_READY, BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL reset_ready_busy: READY=%b BUSY=%b, required 1/0", EV_READY, BUSY);
    end
    checks++;
    if (FIFO_LEVEL !== 5'd0 || EV_SENT_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts: LEVEL=%0d CNT=%0d, required 0/0", FIFO_LEVEL, EV_SENT_CNT);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    push_ev(12'h3A5);                // pushed at edge t
    tick();                          // after t+1
    checks++;
    if (AERIN_ADDR !== 12'h3A5 || AERIN_REQ !== 1'b0) begin
      errors++;
      $display("FAIL single_setup: ADDR=%h REQ=%b, required 3a5/0", AERIN_ADDR, AERIN_REQ);
    end
    tick();                          // after t+2
    checks++;
    if (AERIN_REQ !== 1'b1 || AERIN_ADDR !== 12'h3A5) begin
      errors++;
      $display("FAIL single_req_rise: REQ=%b ADDR=%h, required 1/3a5", AERIN_REQ, AERIN_ADDR);
    end
    repeat (3) tick();
    AERIN_ACK = 1'b1;
    n = 0;
    while (AERIN_REQ !== 1'b0 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== SYNC + 1) begin
      errors++;
      $display("FAIL single_req_fall_latency: %0d edges, required %0d", n, SYNC + 1);
    end
    checks++;
    if (AERIN_ADDR !== 12'h3A5) begin
      errors++;
      $display("FAIL single_addr_hold: ADDR=%h, required 3a5", AERIN_ADDR);
    end
    repeat (3) tick();
    AERIN_ACK = 1'b0;
    repeat (SYNC) tick();
    checks++;
    if (BUSY !== 1'b1 || EV_SENT_CNT !== 16'd0) begin
      errors++;
      $display("FAIL single_ack_lo_hold: BUSY=%b CNT=%0d, required 1/0", BUSY, EV_SENT_CNT);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || EV_SENT_CNT !== 16'd1) begin
      errors++;
      $display("FAIL single_done: BUSY=%b CNT=%0d, required 0/1", BUSY, EV_SENT_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [AW-1:0] exp_a;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      exp_a = 12'hA00 + 12'(i * 3);
      push_ev(exp_a);
    end
    checks++;
    if (EV_READY !== 1'b0 || FIFO_LEVEL !== 5'd16) begin
      errors++;
      $display("FAIL b2b_full: READY=%b LEVEL=%0d, required 0/16", EV_READY, FIFO_LEVEL);
    end
    push_ev(12'hFFF);                // ignored while full
    checks++;
    if (FIFO_LEVEL !== 5'd16) begin
      errors++;
      $display("FAIL b2b_push_when_full: LEVEL=%0d, required 16", FIFO_LEVEL);
    end
    for (int i = 0; i < 17; i++) begin
      exp_a = 12'hA00 + 12'(i * 3);
      respond(1, a);
      checks++;
      if (a !== exp_a) begin
        errors++;
        $display("FAIL b2b_order[%0d]: ADDR=%h, required %h", i, a, exp_a);
      end
    end
    wait_idle("b2b");
    checks++;
    if (EV_SENT_CNT !== 16'd17 || FIFO_LEVEL !== 5'd0) begin
      errors++;
      $display("FAIL b2b_count: CNT=%0d LEVEL=%0d, required 17/0", EV_SENT_CNT, FIFO_LEVEL);
    end
  endtask

  task automatic test_no_ack();
    int n;
    int bad;
    apply_reset();
    push_ev(12'h7C2);
    push_ev(12'h0FF);
    n = 0;
    while (AERIN_REQ !== 1'b1 && n < 10) begin tick(); n++; end
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (AERIN_REQ !== 1'b1 || AERIN_ADDR !== 12'h7C2 || FIFO_LEVEL !== 5'd1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL no_ack_hold: %0d unstable cycles, required 0 (REQ=%b ADDR=%h LEVEL=%0d)",
               bad, AERIN_REQ, AERIN_ADDR, FIFO_LEVEL);
    end
    checks++;
    if (EV_SENT_CNT !== 16'd0) begin
      errors++;
      $display("FAIL no_ack_count: CNT=%0d, required 0", EV_SENT_CNT);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    int n;
    apply_reset();
    push_ev(12'h111);
    respond(0, a);
    wait_idle("mid_pre");
    for (int i = 0; i < 6; i++) push_ev(12'h200 + 12'(i));
    n = 0;
    while (AERIN_REQ !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (AERIN_REQ !== 1'b1 || FIFO_LEVEL !== 5'd5 || EV_SENT_CNT !== 16'd1) begin
      errors++;
      $display("FAIL mid_before: REQ=%b LEVEL=%0d CNT=%0d, required 1/5/1",
               AERIN_REQ, FIFO_LEVEL, EV_SENT_CNT);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (AERIN_REQ !== 1'b0 || AERIN_ADDR !== 12'h0) begin
      errors++;
      $display("FAIL mid_async_req: REQ=%b ADDR=%h, required 0/000", AERIN_REQ, AERIN_ADDR);
    end
    checks++;
    if (FIFO_LEVEL !== 5'd0 || EV_SENT_CNT !== 16'd0) begin
      errors++;
      $display("FAIL mid_async_clear: LEVEL=%0d CNT=%0d, required 0/0", FIFO_LEVEL, EV_SENT_CNT);
    end
    tick();
    RST = 1'b0;
    repeat (10) tick();
    checks++;
    if (AERIN_REQ !== 1'b0 || BUSY !== 1'b0 || EV_READY !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: REQ=%b BUSY=%b READY=%b, required 0/0/1", AERIN_REQ, BUSY, EV_READY);
    end
  endtask

  task automatic test_stale_ack();
    logic [AW-1:0] a;
    apply_reset();
    AERIN_ACK = 1'b1;
    repeat (3) tick();
    push_ev(12'h001);
    repeat (5) tick();
    checks++;
    if (AERIN_REQ !== 1'b0 || FIFO_LEVEL !== 5'd1 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL stale_hold: REQ=%b LEVEL=%0d BUSY=%b, required 0/1/1",
               AERIN_REQ, FIFO_LEVEL, BUSY);
    end
    AERIN_ACK = 1'b0;
    respond(2, a);
    checks++;
    if (a !== 12'h001) begin
      errors++;
      $display("FAIL stale_addr: ADDR=%h, required 001", a);
    end
    wait_idle("stale");
    checks++;
    if (EV_SENT_CNT !== 16'd1) begin
      errors++;
      $display("FAIL stale_count: CNT=%0d, required 1", EV_SENT_CNT);
    end
  endtask

  // 65535 real sends would take ~0.5M cycles; preload the counter instead.
  task automatic test_wrap();
    logic [AW-1:0] a;
    apply_reset();
    force dut.sent_cnt = 16'hFFFF;
    #1;
    release dut.sent_cnt;
    tick();
    checks++;
    if (EV_SENT_CNT !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: CNT=%h, required ffff", EV_SENT_CNT);
    end
    push_ev(12'hC3C);
    respond(0, a);
    wait_idle("wrap");
    checks++;
    if (EV_SENT_CNT !== 16'h0000 || a !== 12'hC3C) begin
      errors++;
      $display("FAIL wrap_count: CNT=%h ADDR=%h, required 0000/c3c", EV_SENT_CNT, a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_no_ack();
    test_reset_mid();
    test_stale_ack();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
